segment_dp: RTL
===============

# segment_dp

Parametrised dynamic-programming segmentation core for the formant path. It consumes a stream of segment costs E(j,i), computes the minimum total cost of splitting bins 0..I-1 into K contiguous segments, and traces back the optimal boundaries. K is selectable at run time up to MAX_SEGMENTS. The core replaces the fixed-count F/B recursion and traceback stage. It sits between the Emin cost generator and the phi frequency stage, with valid/ready handshakes on both sides.

## Interface
- BIT_WIDTH, 32, cost / accumulated-cost width (unsigned)
- I, 160, number of bins; boundary indices 0..I-1
- MAX_SEGMENTS, 8, largest accepted K
- clk_in  input  1  clock
- rst_in  input  1  reset; synchronous, active-high
- start  input  1  one-cycle pulse; latches seg_count, begins a frame
- seg_count  input  $clog2(MAX_SEGMENTS+1)  K for this frame
- cost_valid  input  1  cost_data valid
- cost_ready  output  1  core accepts cost_data this cycle
- cost_data  input  BIT_WIDTH  E(j,i)
- bound_valid  output  1  bound_data valid
- bound_ready  input  1  downstream accepts boundary
- bound_data  output  $clog2(I)  boundary bin index
- bound_index  output  $clog2(MAX_SEGMENTS+1)  boundary number k (K down to 0)
- bound_last  output  1  high with the k=0 boundary
- total_cost  output  BIT_WIDTH  F(K,I-1), valid while done high
- done  output  1  one-cycle pulse at frame end
- busy  output  1  frame in progress
- error  output  1  one-cycle pulse: start with illegal seg_count

## Operation
- Cost stream order: for i=1..I-1, for j=0..i-1, E(j,i). This is I(I-1)/2 words. E(j,i) is the cost of the segment spanning bins j+1..i.
- Recursion: F(k,i) = min over j<i of sat(F(k-1,j)+E(j,i)), with F(0,0)=0 and F(0,j>0)=INF. F(0,·) is implicit, not stored.
- INF = all-ones. The sum saturates to INF on overflow or when either operand is INF.
- Each accepted cost updates all k=1..K in parallel. Row k uses F(k-1,j) read from the row-(k-1) memory, which is register- or BRAM-inferred, depth I, registered read.
- Running min per k starts at INF at column start. It updates only on strictly-less comparisons, so ties keep the smallest j. The argmin j is kept alongside.
- At column end: write F(k,i) = running min, and B(k,i) = argmin, for k=1..K. Rows above K are not written.
- Traceback: b_K = I-1, then b_{k-1} = B(k,b_k) for k=K..1, then b_0 = 0. Emit K+1 boundaries in descending k.
- States:
  - IDLE: busy=0, cost_ready=0.
    - On start with 1<=seg_count<=min(MAX_SEGMENTS,I-1): go to ACCEPT with i=1, j=0.
    - On start with an illegal seg_count: pulse error and stay in IDLE.
  - ACCEPT: cost_ready=1. A transfer occurs on cost_valid&&cost_ready. After the transfer with j==i-1, go to FLUSH.
  - FLUSH: exactly 2 cycles, cost_ready=0. Drains the pipeline and writes column i. Then go to ACCEPT with i+1, j=0, or to TRACE if i==I-1.
  - TRACE: 1-cycle B read per boundary, then present the boundary. Hold the outputs until bound_ready. After the bound_last handshake go to DONE.
  - DONE: one cycle; done=1, total_cost valid. Then IDLE.
- start while busy is ignored. Memory contents are never cleared; every read entry is written earlier in the same frame.

## Timing
- Reset values: cost_ready=0, bound_valid=0, bound_data=0, bound_index=0, bound_last=0, total_cost=0, done=0, busy=0, error=0. The FSM goes to IDLE; reset mid-frame aborts without output.
- busy rises the cycle after start and falls the cycle after DONE.
- Column i with no backpressure takes i+2 cycles.
- The F(k-1,i) read in column i+1 always follows the FLUSH write, so there is no bypass path.
- Boundary outputs: bound_valid rises 2 cycles after TRACE entry. Successive boundaries need at least 2 cycles each (read plus present). bound_data, bound_index and bound_last are stable while bound_valid&&!bound_ready.
- done pulses the cycle after the bound_last handshake. total_cost holds its value until the next start.
- error asserts the cycle after the offending start.

## Test plan
All tests use I=4, MAX_SEGMENTS=4. The cost stream is E(0,1)=5; E(0,2)=9, E(1,2)=1; E(0,3)=20, E(1,3)=7, E(2,3)=3.
- K=1, same costs, bound_ready=1 -> boundaries (k,b) = (1,3),(0,0); total_cost=20.
- K=2, same costs -> (2,3),(1,1),(0,0); total_cost=12. This is a tie between j=1 and j=2, resolved to the smaller j.
- K=3, same costs -> (3,3),(2,2),(1,1),(0,0); total_cost=9. Also check cost_ready: low exactly 2 cycles after each column's last cost; column i open for i accept cycles.
- seg_count=0, then seg_count=4 -> each gives an error pulse and busy stays 0; a following valid start runs normally.
- All costs 0xFFFFFFFF, K=2 -> total_cost=0xFFFFFFFF, no wrap. bound_ready toggling 1-of-3 cycles -> outputs held stable and no boundary lost. rst_in asserted mid-ACCEPT -> all outputs return to reset values next cycle, and the next frame runs correctly.

Source files
------------

// File: rtl/segment_dp.sv
// DP segmentation core: accumulates F(k,i) = min_j sat(F(k-1,j)+E(j,i)) over a
// streamed cost triangle, then traces back the K+1 optimal segment boundaries.
module segment_dp #(
  parameter int unsigned BIT_WIDTH    = 32,
  parameter int unsigned I            = 160,
  parameter int unsigned MAX_SEGMENTS = 8
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic                              start,
  input  logic [$clog2(MAX_SEGMENTS+1)-1:0] seg_count,
  input  logic                              cost_valid,
  output logic                              cost_ready,
  input  logic [BIT_WIDTH-1:0]              cost_data,
  output logic                              bound_valid,
  input  logic                              bound_ready,
  output logic [$clog2(I)-1:0]              bound_data,
  output logic [$clog2(MAX_SEGMENTS+1)-1:0] bound_index,
  output logic                              bound_last,
  output logic [BIT_WIDTH-1:0]              total_cost,
  output logic                              done,
  output logic                              busy,
  output logic                              error
);

  localparam int unsigned KW      = $clog2(MAX_SEGMENTS + 1);
  localparam int unsigned IW      = $clog2(I);
  localparam int unsigned K_LIMIT = (MAX_SEGMENTS < I - 1) ? MAX_SEGMENTS : I - 1;
  localparam logic [BIT_WIDTH-1:0] INF = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_ACCEPT, S_FLUSH, S_TRACE_RD, S_TRACE_OUT, S_DONE
  } state_t;

  state_t state, state_nx;

  logic [KW-1:0]        seg_k, k_cur;
  logic [IW-1:0]        col_i, row_j, j_q, b_cur, b_rd, b_next;
  logic                 flush_cnt, v_q;
  logic [BIT_WIDTH-1:0] cost_q, cost_fin, min_at_k;
  logic                 cost_ready_nx, busy_nx, bound_valid_nx, done_nx, error_nx;
  logic                 start_ok, xfer, col_end, last_col, flush_end, bound_hs;

  logic [BIT_WIDTH-1:0] f_mem   [1:MAX_SEGMENTS-1][0:I-1];
  logic [IW-1:0]        b_mem   [2:MAX_SEGMENTS][0:I-1];
  logic [BIT_WIDTH-1:0] f_rd    [2:MAX_SEGMENTS];
  logic [BIT_WIDTH-1:0] cand    [1:MAX_SEGMENTS];
  logic [BIT_WIDTH-1:0] run_min [1:MAX_SEGMENTS];
  logic [IW-1:0]        run_arg [1:MAX_SEGMENTS];

  function automatic logic [BIT_WIDTH-1:0] sat_add(input logic [BIT_WIDTH-1:0] a,
                                                   input logic [BIT_WIDTH-1:0] b);
    logic [BIT_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[BIT_WIDTH] ? INF : s[BIT_WIDTH-1:0];
  endfunction

  assign start_ok  = (seg_count != '0) && (seg_count <= KW'(K_LIMIT));
  assign xfer      = (state == S_ACCEPT) && cost_valid;
  assign col_end   = (row_j == col_i - IW'(1));
  assign last_col  = (col_i == IW'(I - 1));
  assign flush_end = (state == S_FLUSH) && flush_cnt;
  assign bound_hs  = (state == S_TRACE_OUT) && bound_ready;

  // State and registered control outputs
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state       <= S_IDLE;
      cost_ready  <= 1'b0;
      busy        <= 1'b0;
      bound_valid <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      state       <= state_nx;
      cost_ready  <= cost_ready_nx;
      busy        <= busy_nx;
      bound_valid <= bound_valid_nx;
      done        <= done_nx;
      error       <= error_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:      if (start && start_ok) state_nx = S_ACCEPT;
      S_ACCEPT:    if (xfer && col_end) state_nx = S_FLUSH;
      S_FLUSH:     if (flush_cnt) state_nx = last_col ? S_TRACE_RD : S_ACCEPT;
      S_TRACE_RD:  state_nx = S_TRACE_OUT;
      S_TRACE_OUT: if (bound_ready) state_nx = bound_last ? S_DONE : S_TRACE_RD;
      S_DONE:      state_nx = S_IDLE;
      default:     state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    cost_ready_nx  = (state_nx == S_ACCEPT);
    busy_nx        = (state_nx != S_IDLE);
    bound_valid_nx = (state_nx == S_TRACE_OUT);
    done_nx        = (state_nx == S_DONE);
    error_nx       = (state == S_IDLE) && start && !start_ok;
  end

  // Row 1 sees the implicit F(0,.); column 0 of any stored row is INF by definition
  always_comb begin
    cand[1] = sat_add((j_q == '0) ? '0 : INF, cost_q);
    for (int k = 2; k <= int'(MAX_SEGMENTS); k++)
      cand[k] = sat_add((j_q == '0) ? INF : f_rd[k], cost_q);
    min_at_k = INF;
    for (int k = 1; k <= int'(MAX_SEGMENTS); k++)
      if (KW'(k) == seg_k) min_at_k = run_min[k];
  end

  // Next traceback boundary: b_K is fixed, b_0 is fixed, others come from B(k+1, b_{k+1})
  always_comb begin
    b_rd = '0;
    for (int k = 2; k <= int'(MAX_SEGMENTS); k++)
      if (KW'(k) == k_cur + KW'(1)) b_rd = b_mem[k][b_cur];
    if (k_cur == seg_k)                    b_next = IW'(I - 1);
    else if (k_cur == '0 || b_cur == '0)  b_next = '0;
    else                                   b_next = b_rd;
  end

  always_ff @(posedge clk_in) begin
    if (xfer)
      for (int k = 2; k <= int'(MAX_SEGMENTS); k++) f_rd[k] <= f_mem[k-1][row_j];
    if (flush_end) begin
      for (int k = 1; k < int'(MAX_SEGMENTS); k++)
        if (KW'(k) <= seg_k) f_mem[k][col_i] <= run_min[k];
      for (int k = 2; k <= int'(MAX_SEGMENTS); k++)
        if (KW'(k) <= seg_k) b_mem[k][col_i] <= run_arg[k];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      seg_k       <= '0;
      k_cur       <= '0;
      col_i       <= '0;
      row_j       <= '0;
      j_q         <= '0;
      b_cur       <= '0;
      flush_cnt   <= 1'b0;
      v_q         <= 1'b0;
      cost_q      <= '0;
      cost_fin    <= '0;
      bound_data  <= '0;
      bound_index <= '0;
      bound_last  <= 1'b0;
      total_cost  <= '0;
      for (int k = 1; k <= int'(MAX_SEGMENTS); k++) begin
        run_min[k] <= INF;
        run_arg[k] <= '0;
      end
    end else begin
      v_q       <= xfer;
      flush_cnt <= (state == S_FLUSH) && !flush_cnt;
      if (state == S_IDLE && start && start_ok) begin
        seg_k <= seg_count;
        col_i <= IW'(1);
        row_j <= '0;
      end
      if (xfer) begin
        cost_q <= cost_data;
        j_q    <= row_j;
        row_j  <= col_end ? '0 : row_j + IW'(1);
      end
      // Strict less-than keeps the smallest j on ties
      if (v_q)
        for (int k = 1; k <= int'(MAX_SEGMENTS); k++)
          if (cand[k] < run_min[k]) begin
            run_min[k] <= cand[k];
            run_arg[k] <= j_q;
          end
      if (flush_end) begin
        for (int k = 1; k <= int'(MAX_SEGMENTS); k++) begin
          run_min[k] <= INF;
          run_arg[k] <= '0;
        end
        col_i <= col_i + IW'(1);
        if (last_col) begin
          cost_fin <= min_at_k;
          k_cur    <= seg_k;
        end
      end
      if (state == S_TRACE_RD) begin
        bound_data  <= b_next;
        bound_index <= k_cur;
        bound_last  <= (k_cur == '0);
        b_cur       <= b_next;
      end
      if (bound_hs && !bound_last) k_cur <= k_cur - KW'(1);
      if (bound_hs && bound_last) total_cost <= cost_fin;
    end
  end

endmodule
